// File: rtl/uart_tx_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared types and constants for the uart_tx arbiter slice.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } uart_arb_state_t;

  localparam int UART_DEFAULT_DATA_BITS = 8;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : uart_tx_arbiter_if
// Brief  : Requester and uart_tx handshake bundle around the arbiter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int N_DATA_BITS = 8
);

  logic [N_REQ-1:0]             i_req_valid;
  logic [N_REQ*N_DATA_BITS-1:0] i_req_data;
  logic [N_REQ-1:0]             i_req_last;
  logic [N_REQ-1:0]             o_req_ready;
  logic [N_REQ-1:0]             o_grant;
  logic                         o_tx_data_valid;
  logic [N_DATA_BITS-1:0]       o_tx_data;
  logic                         i_tx_ready;
  logic                         o_timeout;

  // Arbiter side
  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_grant, o_tx_data_valid, o_tx_data, o_timeout
  );

  // Requesters plus uart_tx side
  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_grant, o_tx_data_valid, o_tx_data, o_timeout
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module : rr_pick
// Brief  : Combinational round-robin picker: first request at or after ptr.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [PTR_W:0] c_N = (PTR_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [PTR_W-1:0]   w_off;
  logic [PTR_W:0]     w_sum;

  // Rotating the doubled vector puts the pointer position at bit 0
  assign w_dbl = {i_req, i_req};
  assign w_rot = N_REQ'(w_dbl >> i_ptr);
  assign o_any = |i_req;

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = PTR_W'(i);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= c_N) ? PTR_W'(w_sum - c_N) : w_sum[PTR_W-1:0];

  generate
    for (genvar k = 0; k < N_REQ; k++) begin : g_onehot
      assign o_grant[k] = o_any && (o_idx == PTR_W'(k));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module : uart_tx_arbiter
// Brief  : Packet-locked round-robin arbiter feeding one uart_tx serialiser.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int N_DATA_BITS = UART_DEFAULT_DATA_BITS,
  parameter int TIMEOUT     = 1024
) (
  input  logic              i_uart_clk,
  input  logic              i_uart_reset_n,
  input  logic              i_uart_en,
  uart_tx_arbiter_if.slave  bus
);

  localparam int c_PTR_W = $clog2(N_REQ);
  localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT  = c_CNT_W'(TIMEOUT);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(N_REQ - 1);

  uart_arb_state_t        r_state, w_state_nxt;
  logic [N_REQ-1:0]       r_grant, w_grant_nxt;
  logic [c_PTR_W-1:0]     r_idx, w_idx_nxt;
  logic [c_PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                   r_timeout, w_timeout_nxt;
  logic                   r_tx_valid, w_tx_valid_nxt;
  logic [N_DATA_BITS-1:0] r_tx_data, w_tx_data_nxt;

  logic [N_REQ-1:0]       w_pick_grant;
  logic [c_PTR_W-1:0]     w_pick_idx;
  logic                   w_pick_any;
  logic [N_REQ-1:0]       w_ready;
  logic [N_DATA_BITS-1:0] w_sel_data;
  logic [c_PTR_W-1:0]     w_ptr_inc;
  logic                   w_slot_free, w_req_beat, w_tx_beat;
  logic                   w_holder_valid, w_holder_last, w_expired;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (c_PTR_W)
  ) u_rr_pick (
    .i_req   (bus.i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_slot_free    = !r_tx_valid || bus.i_tx_ready;
  assign w_ready        = (i_uart_en && (r_state == LOCKED) && w_slot_free) ? r_grant : '0;
  assign w_req_beat     = |(bus.i_req_valid & w_ready);
  assign w_tx_beat      = r_tx_valid && bus.i_tx_ready;
  assign w_holder_valid = bus.i_req_valid[r_idx];
  assign w_holder_last  = bus.i_req_last[r_idx];
  assign w_sel_data     = bus.i_req_data[r_idx*N_DATA_BITS +: N_DATA_BITS];
  assign w_expired      = (TIMEOUT > 0) && (r_cnt == c_TIMEOUT);
  assign w_ptr_inc      = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_idx_nxt      = r_idx;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_timeout_nxt  = r_timeout;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    if (i_uart_en) begin
      w_timeout_nxt = 1'b0;
      if (w_req_beat) begin
        w_tx_data_nxt  = w_sel_data;
        w_tx_valid_nxt = 1'b1;
      end else if (w_tx_beat) begin
        w_tx_valid_nxt = 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            w_grant_nxt = w_pick_grant;
            w_idx_nxt   = w_pick_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // A beat always wins over an expiry landing in the same cycle
          if (w_req_beat) begin
            w_cnt_nxt = '0;
            if (w_holder_last) begin
              w_grant_nxt = '0;
              w_ptr_nxt   = w_ptr_inc;
              w_state_nxt = IDLE;
            end
          end else if (w_expired) begin
            w_grant_nxt   = '0;
            w_ptr_nxt     = w_ptr_inc;
            w_timeout_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else if ((TIMEOUT > 0) && !w_holder_valid && (r_cnt != c_TIMEOUT)) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_uart_clk) begin
    if (!i_uart_reset_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_idx      <= w_idx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  assign bus.o_req_ready     = w_ready;
  assign bus.o_grant         = r_grant;
  assign bus.o_tx_data_valid = r_tx_valid;
  assign bus.o_tx_data       = r_tx_data;
  assign bus.o_timeout       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_uart_tx_arbiter
// Brief  : Directed plus randomized bench with a packet-level reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int W  = UART_DEFAULT_DATA_BITS;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .N_DATA_BITS(W)) ifc ();

  uart_tx_arbiter #(
    .N_REQ       (N),
    .N_DATA_BITS (W),
    .TIMEOUT     (TO)
  ) dut (
    .i_uart_clk     (clk),
    .i_uart_reset_n (rst_n),
    .i_uart_en      (en),
    .bus            (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Each entry is {last, data}
  logic [8:0] drv_q [N][$];
  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];
  int         busy = 0;
  bit         stall = 1'b0;
  int         m_ptr = 0;
  int         beat_bad = 0;
  logic [N-1:0] grant_or = '0;
  int         to_pulses = 0;
  int         to_cyc = -1;
  logic [N-1:0] to_grant = '0;
  int         cyc = 0;
  int         last_beat_cyc [N];
  int         beats_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    logic [8:0] h;
    for (int k = 0; k < N; k++) begin
      if (drv_q[k].size() > 0) begin
        h = drv_q[k][0];
        ifc.i_req_valid[k]        = 1'b1;
        ifc.i_req_data[k*W +: W]  = h[7:0];
        ifc.i_req_last[k]         = h[8];
      end else begin
        ifc.i_req_valid[k]        = 1'b0;
        ifc.i_req_data[k*W +: W]  = '0;
        ifc.i_req_last[k]         = 1'b0;
      end
    end
  endtask

  // One clock: observe at negedge, update requesters and uart_tx model after posedge
  task automatic step();
    logic [N-1:0] pop;
    bit acc;
    @(negedge clk);
    cyc++;
    pop = rst_n ? (ifc.i_req_valid & ifc.o_req_ready) : '0;
    for (int k = 0; k < N; k++) begin
      if (pop[k]) begin
        beats_total++;
        last_beat_cyc[k] = cyc;
        if (!ifc.o_grant[k]) beat_bad++;
      end
    end
    acc = en && rst_n && ifc.o_tx_data_valid && ifc.i_tx_ready;
    if (acc) rx_q.push_back(ifc.o_tx_data);
    grant_or |= ifc.o_grant;
    if (ifc.o_timeout) begin
      to_pulses++;
      to_cyc   = cyc;
      to_grant = ifc.o_grant;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (pop[k]) void'(drv_q[k].pop_front());
    if (acc) busy = 9;
    else if (busy > 0 && en) busy--;
    ifc.i_tx_ready = (busy == 0) && !stall;
    present();
  endtask

  // Reference: round-robin over whole packets starting at the model pointer
  task automatic plan();
    logic [8:0] cp [N][$];
    logic [8:0] e;
    int found;
    for (int k = 0; k < N; k++) cp[k] = drv_q[k];
    forever begin
      found = -1;
      for (int i = 0; i < N; i++) begin
        if (found < 0 && cp[(m_ptr + i) % N].size() > 0) found = (m_ptr + i) % N;
      end
      if (found < 0) break;
      do begin
        e = cp[found].pop_front();
        exp_q.push_back(e[7:0]);
      end while (!e[8]);
      m_ptr = (found + 1) % N;
    end
  endtask

  task automatic drain();
    int n = 0;
    bit empty;
    forever begin
      empty = 1'b1;
      for (int k = 0; k < N; k++) if (drv_q[k].size() > 0) empty = 1'b0;
      if (n >= 3000 || (empty && !ifc.o_tx_data_valid && rx_q.size() >= exp_q.size())) break;
      step();
      n++;
    end
  endtask

  task automatic check_stream(input string tag);
    int mism = 0;
    int len;
    chk({tag, " length"}, rx_q.size(), exp_q.size());
    len = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < len; i++) if (rx_q[i] !== exp_q[i]) mism++;
    chk({tag, " byte mismatches"}, mism, 0);
    chk({tag, " beats off-grant"}, beat_bad, 0);
    rx_q.delete();
    exp_q.delete();
    beat_bad = 0;
  endtask

  task automatic push_pkt(input int k, input logic [7:0] b0, input int len, input bit with_last);
    for (int b = 0; b < len; b++) begin
      drv_q[k].push_back({(with_last && b == len - 1), 8'(b0 + 8'(b))});
    end
  endtask

  initial begin
    logic [7:0]   d;
    logic [N-1:0] g;
    logic         v;
    int           bad_d, bad_r, bad_g, n;

    ifc.i_req_valid = '0;
    ifc.i_req_data  = '0;
    ifc.i_req_last  = '0;
    ifc.i_tx_ready  = 1'b1;

    // Reset with every requester holding a packet
    for (int k = 0; k < N; k++) push_pkt(k, 8'(k * 16), 2, 1'b1);
    push_pkt(0, 8'h02, 2, 1'b1);
    push_pkt(1, 8'h12, 2, 1'b1);
    present();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset grant", ifc.o_grant, 0);
      chk("reset tx_valid", ifc.o_tx_data_valid, 0);
      chk("reset ready", ifc.o_req_ready, 0);
    end
    plan();
    rst_n = 1'b1;
    step();
    chk("first grant", ifc.o_grant, 4'b0001);
    chk("first ready", ifc.o_req_ready, 4'b0001);
    drain();
    check_stream("fairness");

    // Single packet from req2
    push_pkt(2, 8'h41, 3, 1'b1);
    present();
    plan();
    grant_or = '0;
    drain();
    chk("single grant", grant_or, 4'b0100);
    check_stream("single");

    // Pointer now at 3: req3 must beat req0
    push_pkt(0, 8'h05, 1, 1'b1);
    push_pkt(3, 8'h35, 1, 1'b1);
    present();
    plan();
    drain();
    check_stream("pointer");

    // Back-pressure with a byte parked in the output register
    stall = 1'b1;
    ifc.i_tx_ready = 1'b0;
    push_pkt(1, 8'hA0, 3, 1'b1);
    present();
    plan();
    n = 0;
    while (n < 20 && !ifc.o_tx_data_valid) begin step(); n++; end
    chk("bp loaded", ifc.o_tx_data_valid, 1);
    d = ifc.o_tx_data;
    chk("bp first byte", d, 8'hA0);
    bad_d = 0; bad_r = 0; to_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ifc.o_tx_data !== d) bad_d++;
      if (ifc.o_req_ready !== '0) bad_r++;
    end
    chk("bp data moved", bad_d, 0);
    chk("bp ready leaked", bad_r, 0);
    chk("bp timeout", to_pulses, 0);
    stall = 1'b0;
    ifc.i_tx_ready = (busy == 0);
    drain();
    check_stream("backpressure");

    // Timeout: req1 stalls mid-packet, req3 waits
    push_pkt(1, 8'h10, 1, 1'b0);
    present();
    to_pulses = 0;
    n = 0;
    while (n < 10 && ifc.o_grant !== 4'b0010) begin step(); n++; end
    chk("to holder grant", ifc.o_grant, 4'b0010);
    push_pkt(3, 8'h30, 2, 1'b1);
    present();
    n = 0;
    while (n < 60 && to_pulses == 0) begin step(); n++; end
    chk("to latency", to_cyc - last_beat_cyc[1], TO + 2);
    chk("to grant released", to_grant, 0);
    chk("to next grant", ifc.o_grant, 4'b1000);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    m_ptr = 0;
    drain();
    chk("to pulse count", to_pulses, 1);
    check_stream("timeout");

    // Randomized packet batches
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        int np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) drv_q[k].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      present();
      plan();
      drain();
      check_stream("random");
    end

    // Freeze mid-packet, then reset
    push_pkt(2, 8'h50, 4, 1'b1);
    present();
    beats_total = 0;
    n = 0;
    while (n < 20 && beats_total == 0) begin step(); n++; end
    chk("freeze holder", ifc.o_grant, 4'b0100);
    en = 1'b0;
    g = ifc.o_grant; v = ifc.o_tx_data_valid; d = ifc.o_tx_data;
    bad_g = 0; bad_r = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ifc.o_grant !== g || ifc.o_tx_data_valid !== v || ifc.o_tx_data !== d) bad_g++;
      if (ifc.o_req_ready !== '0) bad_r++;
    end
    chk("freeze state moved", bad_g, 0);
    chk("freeze ready", bad_r, 0);
    en = 1'b1;
    rst_n = 1'b0;
    step();
    chk("midreset tx_valid", ifc.o_tx_data_valid, 0);
    chk("midreset grant", ifc.o_grant, 0);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) drv_q[k].delete();
    present();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
